// File: rtl/frame_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : frame_scheduler
// Brief    : Animation sequencer; rewrites the display frame-address register
//            over a Wishbone master port on display-frame boundaries.
//            Optional ping-pong sequencing: FRAME_SCHED_PINGPONG_EN.
// Revision : 1.0 - initial release
// =============================================================================
module frame_scheduler #(
  parameter int                       ADDRESS_WIDTH    = 30,
  parameter int                       DATA_WIDTH       = 32,
  parameter int                       FRAME_ADDR_WIDTH = 14,
  parameter logic [ADDRESS_WIDTH-1:0] TARGET_ADDRESS   = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // configuration slave
  input  logic [ADDRESS_WIDTH-1:0] s_adr_i,
  input  logic [DATA_WIDTH-1:0]    s_dat_i,
  output logic [DATA_WIDTH-1:0]    s_dat_o,
  input  logic                     s_we_i,
  input  logic                     s_stb_i,
  input  logic                     s_cyc_i,
  input  logic [3:0]               s_sel_i,
  output logic                     s_ack_o,
  // frame-address master
  output logic [ADDRESS_WIDTH-1:0] m_adr_o,
  output logic [DATA_WIDTH-1:0]    m_dat_o,
  output logic                     m_we_o,
  output logic                     m_stb_o,
  output logic                     m_cyc_o,
  output logic [3:0]               m_sel_o,
  input  logic                     m_ack_i,
  // display
  input  logic                     frame_complete_i,
  output logic                     irq_o
);

  localparam int c_PAD_W = DATA_WIDTH - FRAME_ADDR_WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // configuration registers
  logic                        r_en;
  logic                        r_loop;
  logic [DATA_WIDTH-1:0]       r_base;
  logic [23:0]                 r_geom;
  logic [7:0]                  r_delay;
  logic                        w_pp;

  // sequencer state
  state_t                      r_state, w_state_nxt;
  logic [7:0]                  r_index, w_index_nxt;
  logic [FRAME_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [7:0]                  r_dcnt, w_dcnt_nxt;
  logic                        r_dir, w_dir_nxt;
  logic                        r_done, w_done_nxt;
  logic                        r_irq, w_irq_nxt;
  logic                        r_pend, w_pend_nxt;
  logic                        r_m_cyc, w_m_cyc_nxt;
  logic                        w_finish;

  logic                        r_s_ack;
  logic                        r_en_q;
  logic                        r_fc_q;
  logic                        w_tick;
  logic                        w_wr;
  logic                        w_ctl_wr;
  logic                        w_irq_clr;
  logic [7:0]                  w_count;
  logic [7:0]                  w_last;
  logic [15:0]                 w_stride;
  logic [FRAME_ADDR_WIDTH-1:0] w_stride_hw;
  logic [FRAME_ADDR_WIDTH-1:0] w_base_hw;
  logic                        w_unused;

  assign w_unused = ^s_adr_i[ADDRESS_WIDTH-1:2];

  // ---------------------------------------------------------------------------
  // Slave port
  // ---------------------------------------------------------------------------
  assign s_ack_o   = r_s_ack;
  assign w_wr      = r_s_ack & s_cyc_i & s_stb_i & s_we_i;
  assign w_ctl_wr  = w_wr & (s_adr_i[1:0] == 2'd0) & s_sel_i[0];
  assign w_irq_clr = w_ctl_wr & s_dat_i[2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s_ack <= 1'b0;
    end else begin
      r_s_ack <= s_cyc_i & s_stb_i & ~r_s_ack;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_en    <= 1'b0;
      r_loop  <= 1'b0;
      r_base  <= '0;
      r_geom  <= '0;
      r_delay <= '0;
    end else if (w_wr) begin
      case (s_adr_i[1:0])
        2'd0: begin
          if (s_sel_i[0]) begin
            r_en   <= s_dat_i[0];
            r_loop <= s_dat_i[1];
          end
        end
        2'd1: begin
          for (int b = 0; b < 4; b++) begin
            if (s_sel_i[b]) r_base[8*b +: 8] <= s_dat_i[8*b +: 8];
          end
        end
        2'd2: begin
          for (int b = 0; b < 3; b++) begin
            if (s_sel_i[b]) r_geom[8*b +: 8] <= s_dat_i[8*b +: 8];
          end
        end
        default: begin
          if (s_sel_i[0]) r_delay <= s_dat_i[7:0];
        end
      endcase
    end
  end

`ifdef FRAME_SCHED_PINGPONG_EN
  logic r_pp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pp <= 1'b0;
    end else if (w_ctl_wr) begin
      r_pp <= s_dat_i[3];
    end
  end

  assign w_pp = r_pp;
`else
  assign w_pp = 1'b0;
`endif

  always_comb begin
    s_dat_o = '0;
    if (s_cyc_i && s_stb_i) begin
      case (s_adr_i[1:0])
        2'd0: begin
          s_dat_o[0]     = r_en;
          s_dat_o[1]     = r_loop;
          s_dat_o[3]     = w_pp;
          s_dat_o[4]     = r_done;
          s_dat_o[5]     = (r_state != S_IDLE);
          s_dat_o[23:16] = r_index;
        end
        2'd1:    s_dat_o        = r_base;
        2'd2:    s_dat_o[23:0]  = r_geom;
        default: s_dat_o[7:0]   = r_delay;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  assign w_tick      = frame_complete_i & ~r_fc_q;
  assign w_count     = (r_geom[23:16] == 8'd0) ? 8'd1 : r_geom[23:16];
  assign w_last      = w_count - 8'd1;
  assign w_stride    = r_geom[15:0];
  assign w_stride_hw = FRAME_ADDR_WIDTH'(w_stride >> 1);
  assign w_base_hw   = r_base[FRAME_ADDR_WIDTH:1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_addr  <= '0;
      r_dcnt  <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
      r_irq   <= 1'b0;
      r_pend  <= 1'b0;
      r_m_cyc <= 1'b0;
      r_en_q  <= 1'b0;
      r_fc_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_addr  <= w_addr_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_dir   <= w_dir_nxt;
      r_done  <= w_done_nxt;
      r_irq   <= w_irq_nxt;
      r_pend  <= w_pend_nxt;
      r_m_cyc <= w_m_cyc_nxt;
      r_en_q  <= r_en;
      r_fc_q  <= frame_complete_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_addr_nxt  = r_addr;
    w_dcnt_nxt  = r_dcnt;
    w_dir_nxt   = r_dir;
    w_done_nxt  = r_done;
    w_irq_nxt   = r_irq;
    w_pend_nxt  = r_pend;
    w_m_cyc_nxt = r_m_cyc;
    w_finish    = 1'b0;

    // a completion in the same cycle overrides the clear below
    if (w_irq_clr) w_irq_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_pend_nxt = 1'b0;
        if (r_en && !r_en_q) begin
          w_index_nxt = 8'd0;
          w_addr_nxt  = w_base_hw;
          w_dcnt_nxt  = r_delay;
          w_done_nxt  = 1'b0;
          w_dir_nxt   = 1'b0;
          w_state_nxt = S_REQ;
        end
      end

      S_REQ: begin
        if (w_tick) w_pend_nxt = 1'b1;
        if (!r_m_cyc) begin
          w_m_cyc_nxt = 1'b1;
        end else if (m_ack_i) begin
          w_m_cyc_nxt = 1'b0;
          w_state_nxt = r_en ? S_WAIT : S_IDLE;
        end
      end

      S_WAIT: begin
        w_pend_nxt = 1'b0;
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick || r_pend) begin
          if (r_dcnt != 8'd0) begin
            w_dcnt_nxt = r_dcnt - 8'd1;
          end else begin
            w_dcnt_nxt  = r_delay;
            w_state_nxt = S_REQ;
            if (w_pp && r_dir) begin
              if (r_index != 8'd0) begin
                w_index_nxt = r_index - 8'd1;
                w_addr_nxt  = r_addr - w_stride_hw;
              end else if (r_loop) begin
                // bounce off the bottom without repeating frame 0
                w_dir_nxt = 1'b0;
                if (w_count > 8'd1) begin
                  w_index_nxt = 8'd1;
                  w_addr_nxt  = w_base_hw + w_stride_hw;
                end else begin
                  w_index_nxt = 8'd0;
                  w_addr_nxt  = w_base_hw;
                end
              end else begin
                w_finish = 1'b1;
              end
            end else if (r_index < w_last) begin
              w_index_nxt = r_index + 8'd1;
              w_addr_nxt  = r_addr + w_stride_hw;
            end else if (w_pp && w_count > 8'd1) begin
              w_dir_nxt   = 1'b1;
              w_index_nxt = r_index - 8'd1;
              w_addr_nxt  = r_addr - w_stride_hw;
            end else if (r_loop) begin
              w_index_nxt = 8'd0;
              w_addr_nxt  = w_base_hw;
            end else begin
              w_finish = 1'b1;
            end

            if (w_finish) begin
              w_done_nxt  = 1'b1;
              w_irq_nxt   = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Master port
  // ---------------------------------------------------------------------------
  assign m_adr_o = TARGET_ADDRESS;
  assign m_dat_o = {{c_PAD_W{1'b0}}, r_addr, 1'b0};
  assign m_sel_o = 4'b0011;
  assign m_cyc_o = r_m_cyc;
  assign m_stb_o = r_m_cyc;
  assign m_we_o  = r_m_cyc;
  assign irq_o   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : tb_frame_scheduler
// Brief    : Directed self-checking bench for frame_scheduler.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
module tb_frame_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [29:0] s_adr_i;
  logic [31:0] s_dat_i;
  logic [31:0] s_dat_o;
  logic        s_we_i, s_stb_i, s_cyc_i;
  logic [3:0]  s_sel_i;
  logic        s_ack_o;
  logic [29:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic        m_we_o, m_stb_o, m_cyc_o;
  logic [3:0]  m_sel_o;
  logic        m_ack_i;
  logic        frame_complete_i;
  logic        irq_o;

  int total = 0;
  int bad   = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;
  int stb_run   = 0;
  int stb_len   = 0;
  logic [31:0] wr_log[$];
  logic [31:0] rd;

  frame_scheduler dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .s_adr_i          (s_adr_i),
    .s_dat_i          (s_dat_i),
    .s_dat_o          (s_dat_o),
    .s_we_i           (s_we_i),
    .s_stb_i          (s_stb_i),
    .s_cyc_i          (s_cyc_i),
    .s_sel_i          (s_sel_i),
    .s_ack_o          (s_ack_o),
    .m_adr_o          (m_adr_o),
    .m_dat_o          (m_dat_o),
    .m_we_o           (m_we_o),
    .m_stb_o          (m_stb_o),
    .m_cyc_o          (m_cyc_o),
    .m_sel_o          (m_sel_o),
    .m_ack_i          (m_ack_i),
    .frame_complete_i (frame_complete_i),
    .irq_o            (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // master-side target: acks after ack_delay waiting cycles and logs the data
  initial begin
    m_ack_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (m_cyc_o && m_stb_o && !m_ack_i) begin
        stb_run++;
        if (wait_cnt >= ack_delay) begin
          m_ack_i = 1'b1;
          if (m_we_o) wr_log.push_back(m_dat_o);
          stb_len  = stb_run;
          stb_run  = 0;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        m_ack_i  = 1'b0;
        wait_cnt = 0;
        stb_run  = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] sel);
    int k;
    @(negedge clk_i);
    s_adr_i = {28'd0, a}; s_dat_i = d; s_sel_i = sel;
    s_we_i = 1'b1; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    k = 0;
    do begin @(posedge clk_i); #1; k++; end while (!s_ack_o && k < 10);
    check("wr_ack_latency", k, 1);
    @(posedge clk_i); #1;
    s_we_i = 1'b0; s_cyc_i = 1'b0; s_stb_i = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    int k;
    @(negedge clk_i);
    s_adr_i = {28'd0, a}; s_sel_i = 4'hF;
    s_we_i = 1'b0; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    k = 0;
    do begin @(posedge clk_i); #1; k++; end while (!s_ack_o && k < 10);
    check("rd_ack_latency", k, 1);
    d = s_dat_o;
    @(posedge clk_i); #1;
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
  endtask

  task automatic tick(input int post);
    @(negedge clk_i); frame_complete_i = 1'b1;
    @(negedge clk_i); frame_complete_i = 1'b0;
    if (post > 0) cycles(post);
  endtask

  task automatic wait_stb();
    int k = 0;
    while (!m_stb_o && k < 20) begin @(posedge clk_i); #1; k++; end
    check("stb_seen", {31'd0, m_stb_o}, 32'd1);
  endtask

  initial begin
    rst_i = 1'b1;
    s_adr_i = '0; s_dat_i = '0; s_sel_i = '0;
    s_we_i = 1'b0; s_stb_i = 1'b0; s_cyc_i = 1'b0;
    frame_complete_i = 1'b0;
    cycles(3);

    // reset state
    check("rst_m_cyc", {31'd0, m_cyc_o}, 32'd0);
    check("rst_irq",   {31'd0, irq_o},   32'd0);
    check("rst_m_sel", {28'd0, m_sel_o}, 32'd3);
    check("rst_m_adr", {2'd0, m_adr_o},  32'd0);
    check("rst_m_dat", m_dat_o,          32'd0);
    @(negedge clk_i); rst_i = 1'b0;
    cycles(2);
    check("idle_sdat", s_dat_o, 32'd0);

    // register access and byte selects
    wb_write(2'd1, 32'hAABB_CCDD, 4'hF);
    wb_write(2'd1, 32'h1122_3344, 4'b0010);
    check("single_ack", {31'd0, s_ack_o}, 32'd0);
    wb_read(2'd1, rd);
    check("base_bytesel", rd, 32'hAABB_33DD);
    wb_write(2'd2, 32'hFFFF_FFFF, 4'hF);
    wb_read(2'd2, rd);
    check("geom_mask", rd, 32'h00FF_FFFF);

    // forward sequence, no loop
    wb_write(2'd1, 32'h0000_1000, 4'hF);
    wb_write(2'd2, 32'h0003_0230, 4'hF);
    wb_write(2'd3, 32'h0000_0000, 4'hF);
    wb_write(2'd0, 32'h0000_0001, 4'hF);
    cycles(6);
    check("seq_w0", log_at(0), 32'h0000_1000);
    tick(6);
    check("seq_w1", log_at(1), 32'h0000_1230);
    tick(6);
    check("seq_w2", log_at(2), 32'h0000_1460);
    tick(6);
    check("seq_irq", {31'd0, irq_o}, 32'd1);
    check("seq_count", wr_log.size(), 3);
    wb_read(2'd0, rd);
    check("seq_ctrl_done", rd, 32'h0002_0011);
    wb_write(2'd0, 32'h0000_0005, 4'hF);
    check("irq_clr", {31'd0, irq_o}, 32'd0);
    wb_read(2'd0, rd);
    check("irq_clr_ctrl", rd, 32'h0002_0011);

    // loop with DELAY=2
    wb_write(2'd0, 32'h0000_0000, 4'hF);
    wr_log.delete();
    wb_write(2'd3, 32'h0000_0002, 4'hF);
    wb_write(2'd0, 32'h0000_0003, 4'hF);
    cycles(6);
    check("loop_w0", log_at(0), 32'h0000_1000);
    wb_read(2'd0, rd);
    check("loop_ctrl_busy", rd, 32'h0000_0023);
    tick(6); tick(6);
    check("loop_hold", wr_log.size(), 1);
    tick(6);
    check("loop_w1", log_at(1), 32'h0000_1230);
    tick(6); tick(6); tick(6);
    check("loop_w2", log_at(2), 32'h0000_1460);
    tick(6); tick(6); tick(6);
    check("loop_w3", log_at(3), 32'h0000_1000);

    // slow ack, two ticks during the strobe
    wb_write(2'd0, 32'h0000_0000, 4'hF);
    cycles(4);
    wr_log.delete();
    wb_write(2'd3, 32'h0000_0000, 4'hF);
    ack_delay = 4;
    wb_write(2'd0, 32'h0000_0003, 4'hF);
    wait_stb();
    tick(0);
    tick(0);
    cycles(20);
    check("slow_stb_len", stb_len, 5);
    check("slow_one_tick", wr_log.size(), 2);
    check("slow_w1", log_at(1), 32'h0000_1230);
    ack_delay = 0;

    // 14-bit address wrap
    wb_write(2'd0, 32'h0000_0000, 4'hF);
    cycles(4);
    wr_log.delete();
    wb_write(2'd1, 32'h0000_7F00, 4'hF);
    wb_write(2'd2, 32'h0002_0200, 4'hF);
    wb_write(2'd0, 32'h0000_0001, 4'hF);
    cycles(6);
    check("wrap_w0", log_at(0), 32'h0000_7F00);
    tick(6);
    check("wrap_w1", log_at(1), 32'h0000_0100);
    tick(6);
    check("wrap_irq", {31'd0, irq_o}, 32'd1);

    // COUNT=0 behaves as a single frame
    wb_write(2'd0, 32'h0000_0004, 4'hF);
    check("irq_clr2", {31'd0, irq_o}, 32'd0);
    wr_log.delete();
    wb_write(2'd1, 32'h0000_1000, 4'hF);
    wb_write(2'd2, 32'h0000_0230, 4'hF);
    wb_write(2'd0, 32'h0000_0001, 4'hF);
    cycles(6);
    tick(6);
    check("cnt0_irq", {31'd0, irq_o}, 32'd1);
    check("cnt0_count", wr_log.size(), 1);

    // disabling while waiting returns to idle
    wb_write(2'd0, 32'h0000_0000, 4'hF);
    wb_write(2'd2, 32'h0003_0230, 4'hF);
    wb_write(2'd0, 32'h0000_0003, 4'hF);
    cycles(6);
    wb_write(2'd0, 32'h0000_0000, 4'hF);
    cycles(3);
    wb_read(2'd0, rd);
    check("disable_idle", rd, 32'h0000_0000);

    // CTRL[3]
    wb_write(2'd0, 32'h0000_0008, 4'hF);
    wb_read(2'd0, rd);
`ifdef FRAME_SCHED_PINGPONG_EN
    check("ctrl_pp_bit", rd, 32'h0000_0008);
    wr_log.delete();
    wb_write(2'd0, 32'h0000_000B, 4'hF);
    cycles(6);
    for (int i = 0; i < 5; i++) tick(6);
    check("pp_w0", log_at(0), 32'h0000_1000);
    check("pp_w1", log_at(1), 32'h0000_1230);
    check("pp_w2", log_at(2), 32'h0000_1460);
    check("pp_w3", log_at(3), 32'h0000_1230);
    check("pp_w4", log_at(4), 32'h0000_1000);
    check("pp_w5", log_at(5), 32'h0000_1230);
`else
    check("ctrl_pp_bit", rd, 32'h0000_0000);
`endif
    wb_write(2'd0, 32'h0000_0000, 4'hF);
    cycles(4);

    // reset in the middle of a master cycle
    ack_delay = 100;
    wb_write(2'd0, 32'h0000_0001, 4'hF);
    wait_stb();
    @(negedge clk_i); rst_i = 1'b1;
    #1;
    check("rst_req_cyc", {31'd0, m_cyc_o}, 32'd0);
    check("rst_req_stb", {31'd0, m_stb_o}, 32'd0);
    check("rst_req_irq", {31'd0, irq_o},   32'd0);
    cycles(2);
    @(negedge clk_i); rst_i = 1'b0;
    ack_delay = 0;
    wb_read(2'd0, rd);
    check("rst_req_ctrl", rd, 32'h0000_0000);
    check("rst_req_madr", {2'd0, m_adr_o}, 32'd0);
    check("rst_req_msel", {28'd0, m_sel_o}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
